// File: rtl/weight_fetch_pkg.sv
// Shared types and default widths for the weight ROM fetch arbiter.
package weight_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 9;

endpackage

// File: rtl/weight_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             any_o
);

  // Scan requesters starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    logic found;
    int   idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/weight_fetch_arbiter.sv
// Round-robin burst sequencer sharing one weight ROM between N_REQ requesters.
module weight_fetch_arbiter
  import weight_fetch_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_base,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       w_data,
  output logic                    w_valid,
  output logic                    w_last,
  input  logic                    w_ready,
  output logic [N_REQ-1:0]        done,
  output logic [ADDR_W-1:0]       rom_address,
  output logic                    rom_enable,
  input  logic [DATA_W-1:0]       rom_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic                w_valid_q, w_valid_d;
  logic                w_last_q, w_last_d;
  logic                rom_en_q, rom_en_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;

  logic [N_REQ-1:0]    win_onehot_s;
  logic                win_any_s;
  logic [PTR_W-1:0]    win_idx_s;
  logic [ADDR_W-1:0]   sel_base_s;
  logic [LEN_W-1:0]    sel_len_s;
  logic                capture_s;
  logic [LEN_W-1:0]    issued_inc_s;
  logic                last_cap_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_onehot_s),
    .any_o (win_any_s)
  );

  // Decode the one-hot winner into an index and its request slices.
  always_comb begin
    win_idx_s  = '0;
    sel_base_s = '0;
    sel_len_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_onehot_s[i]) begin
        win_idx_s  = PTR_W'(i);
        sel_base_s = req_base[i*ADDR_W +: ADDR_W];
        sel_len_s  = req_len[i*LEN_W +: LEN_W];
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

  // A ROM word is captured whenever the output slot is empty or being drained.
  assign capture_s    = rom_en_q && (!w_valid_q || w_ready);
  assign issued_inc_s = issued_q + LEN_W'(1);
  assign last_cap_s   = (issued_inc_s == len_q);

  // Next-state and datapath control for the IDLE/FETCH/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    w_data_d   = w_data_q;
    w_valid_d  = w_valid_q;
    w_last_d   = w_last_q;
    rom_en_d   = rom_en_q;
    rom_addr_d = rom_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any_s) begin
          grant_d  = win_onehot_s;
          owner_d  = win_idx_s;
          base_d   = sel_base_s;
          len_d    = sel_len_s;
          issued_d = '0;
          state_d  = ST_FETCH;
          if (sel_len_s != '0) begin
            rom_en_d   = 1'b1;
            rom_addr_d = sel_base_s;
          end else begin
            rom_en_d   = 1'b0;
            rom_addr_d = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (capture_s) begin
          w_data_d  = rom_data;
          w_valid_d = 1'b1;
          w_last_d  = last_cap_s;
          issued_d  = issued_inc_s;
          if (last_cap_s) begin
            rom_en_d   = 1'b0;
            rom_addr_d = '0;
          end else begin
            rom_addr_d = base_q + issued_inc_s[ADDR_W-1:0];
          end
        end else if (w_valid_q && w_ready) begin
          w_valid_d = 1'b0;
          w_last_d  = 1'b0;
          if (w_last_q) begin
            state_d = ST_DONE;
            done_d  = grant_q;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (len_q == '0) begin
          // Zero-length burst: nothing to fetch, complete straight away.
          state_d = ST_DONE;
          done_d  = grant_q;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        state_d = ST_IDLE;
        if (owner_q == PTR_W'(N_REQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = owner_q + PTR_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        w_valid_d  = 1'b0;
        w_last_d   = 1'b0;
        rom_en_d   = 1'b0;
        rom_addr_d = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      w_data_q   <= '0;
      w_valid_q  <= 1'b0;
      w_last_q   <= 1'b0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      w_data_q   <= w_data_d;
      w_valid_q  <= w_valid_d;
      w_last_q   <= w_last_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign w_data      = w_data_q;
  assign w_valid     = w_valid_q;
  assign w_last      = w_last_q;
  assign rom_enable  = rom_en_q;
  assign rom_address = rom_addr_q;

endmodule
